// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_pkg: shared types and constants for the core-side memory bus arbiter.
//   arb_state_t    - access FSM states
//   grant_t        - which core port owns (or last owned) the bus
//   BUS_ABORT_DATA - read data returned when an access times out
//   BE_B/BE_H/BE_W - byte-enable patterns for byte / half / word accesses
//   TMO_W          - width of the per-access timeout counter
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DREAD  = 3'd2,
    ST_DWRITE = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  localparam logic [31:0] BUS_ABORT_DATA = 32'hDEADBEEF;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam int TMO_W = 8;

  // True while a memory strobe is (or should be) outstanding.
  function automatic logic is_access(input arb_state_t s);
    return (s == ST_FETCH) || (s == ST_DREAD) || (s == ST_DWRITE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// bus_timeout_ctr: per-access watchdog counter.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the count (new access granted)
//   enable    - count this cycle (access outstanding, memory still busy)
//   limit     - terminal count
//   expired   - count has reached limit; holds there until cleared
module bus_timeout_ctr
  import mem_bus_pkg::*;
#(
  parameter int CNT_W = TMO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == limit);

  // Saturates at the limit so a stuck enable cannot wrap back below it.
  always_ff @(posedge clk) begin
    if (rst)                     count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the core's
// instruction-fetch port and its load/store port.
//   clk, rst              - clock, synchronous active-high reset
//   i_req/i_addr          - fetch request (held until i_ack) and address
//   i_ack/i_rdata         - one-cycle fetch completion pulse and instruction
//   d_read/d_write        - load / store request (held until d_ack)
//   d_addr/d_wdata/d_be   - load/store address, store data, byte enables
//   d_ack/d_rdata         - one-cycle data completion pulse and load data
//   m_read/m_write        - memory strobes (registered, mutually exclusive)
//   m_addr/m_wdata/m_be   - memory address, write data, byte enables
//   m_busy/m_rdata        - memory busy (low = done) and read data
//   stall                 - freezes the core while any request is unacked
//   err                   - sticky error: timeout abort or read+write together
//
// Access timeline: request seen in IDLE (cycle 0), strobe from cycle 1,
// completion cycle C (m_busy low, never cycle 1), ack in RESP at C+1.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic              m_busy,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall,
  output logic              err
);

  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] ABORT_RD  = DATA_W'(BUS_ABORT_DATA);

  arb_state_t state;
  grant_t     last_grant;
  logic       first_cyc;   // first access cycle: memory may not have raised m_busy yet
  logic       blk_i;       // fetch port just acked, still holding i_req
  logic       blk_d;       // data port just acked, still holding d_read/d_write

  logic in_acc, f_ok, d_ok, take_d, take_f, done, abort, tmo_expired;
  logic [DATA_W-1:0] rd_val;

  // ---------------------------------------------------------------------
  // Arbitration: data normally wins, but a fetch waiting behind a data
  // grant goes next so the two ports alternate under sustained load.
  // ---------------------------------------------------------------------
  assign in_acc = is_access(state);
  assign f_ok   = i_req & ~blk_i;
  assign d_ok   = (d_read | d_write) & ~blk_d;
  assign take_d = (state == ST_IDLE) && d_ok && !((last_grant == GNT_DATA) && f_ok);
  assign take_f = (state == ST_IDLE) && f_ok && !take_d;

  // Normal completion takes priority over a timeout landing the same cycle.
  assign done   = in_acc && !first_cyc && !m_busy;
  assign abort  = in_acc && !done && tmo_expired;
  assign rd_val = done ? m_rdata : ABORT_RD;

  assign stall  = (i_req & ~i_ack) | ((d_read | d_write) & ~d_ack);

  bus_timeout_ctr #(.CNT_W(TMO_W)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (take_d | take_f),
    .enable  (in_acc & m_busy),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );

  // ---------------------------------------------------------------------
  // Access FSM. All bus outputs are registered so they stay stable for the
  // whole access; requests are only looked at in IDLE.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GNT_FETCH;
      first_cyc  <= 1'b0;
      blk_i      <= 1'b0;
      blk_d      <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      err        <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          // Re-issue guard lasts exactly one IDLE cycle.
          blk_i <= 1'b0;
          blk_d <= 1'b0;
          if (take_d) begin
            last_grant <= GNT_DATA;
            first_cyc  <= 1'b1;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            // Read+write together is a core bug; the store side is honoured.
            if (d_write) begin
              state   <= ST_DWRITE;
              m_write <= 1'b1;
              m_be    <= d_be;
            end else begin
              state   <= ST_DREAD;
              m_read  <= 1'b1;
              m_be    <= BE_W;
            end
            if (d_read && d_write) err <= 1'b1;
          end else if (take_f) begin
            last_grant <= GNT_FETCH;
            first_cyc  <= 1'b1;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            m_be       <= BE_W;
            m_read     <= 1'b1;
            state      <= ST_FETCH;
          end
        end

        ST_FETCH, ST_DREAD, ST_DWRITE: begin
          first_cyc <= 1'b0;
          if (done || abort) begin
            state   <= ST_RESP;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (state == ST_FETCH) begin
              i_ack   <= 1'b1;
              i_rdata <= rd_val;
            end else begin
              d_ack <= 1'b1;
              // Stores leave the load-data register untouched.
              if (state == ST_DREAD) d_rdata <= rd_val;
            end
            if (abort) err <= 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
          blk_i <= (last_grant == GNT_FETCH);
          blk_d <= (last_grant == GNT_DATA);
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a scripted memory responder, an ack
// scoreboard (expected responses queued at stimulus time, popped on ack)
// and immediate-assertion checks on latency, strobes and error flag.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_be;
  logic          m_busy = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          stall, err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_busy(m_busy), .m_rdata(m_rdata),
    .stall(stall), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by reads.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h3e80_0093;
      32'h0000_0020: return 32'h0000_0013;
      32'h0000_0200: return 32'h1234_5678;
      default:       return ~a;
    endcase
  endfunction

  // Responder: busy for the first wait_n strobe cycles (or forever if stuck).
  int wait_n = 0;
  bit stuck = 1'b0;
  int acc = 0;
  always @(negedge clk) begin
    if (m_read || m_write) acc = acc + 1;
    else acc = 0;
    m_busy  = stuck || (acc != 0 && acc <= wait_n);
    m_rdata = rd_model(m_addr);
  end

  // Scoreboard of expected acks.
  typedef struct packed {
    logic          is_data;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && (i_ack || d_ack)) begin
      chk("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
      chk("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ack_port", 32'(d_ack), 32'(mon_e.is_data));
        chk("ack_rdata", mon_e.is_data ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges from the current cycle (n=0) until an ack, bounded.
  task automatic wait_ack(input int budget, output int lat, output int nrd, output int nwr,
                          output logic [31:0] fa, output logic [31:0] fw,
                          output logic [3:0] fb, output logic st0);
    lat = -1; nrd = 0; nwr = 0; fa = '0; fw = '0; fb = '0; st0 = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (n == 0) st0 = stall;
      chk("strobe_excl", 32'(m_read & m_write), 32'd0);
      if ((m_read || m_write) && nrd == 0 && nwr == 0) begin
        fa = m_addr; fw = m_wdata; fb = m_be;
      end
      if (m_read)  nrd++;
      if (m_write) nwr++;
      if (i_ack || d_ack) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic watch_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(tag, 32'({m_read, m_write}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  int lat, nrd, nwr;
  logic [31:0] fa, fw;
  logic [3:0]  fb;
  logic        st0;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 32'({m_read, m_write}), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_mwdata", m_wdata, 32'd0);
    chk("rst_mbe", 32'(m_be), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step(); rst = 1'b0;

    // ---- fetch, 2 busy cycles ----
    wait_n = 2;
    sb.push_back('{is_data: 1'b0, rdata: 32'h3e80_0093});
    i_req = 1'b1; i_addr = 32'h10;
    wait_ack(20, lat, nrd, nwr, fa, fw, fb, st0);
    chk("f_lat", lat, 32'd4);
    chk("f_mread_cycles", nrd, 32'd3);
    chk("f_mwrite_cycles", nwr, 32'd0);
    chk("f_maddr", fa, 32'h10);
    chk("f_mbe", 32'(fb), 32'hF);
    chk("f_stall_wait", 32'(st0), 32'd1);
    chk("f_dack", 32'(d_ack), 32'd0);
    step(); i_req = 1'b0;
    @(negedge clk);
    chk("f_stall_after", 32'(stall), 32'd0);
    chk("f_iack_after", 32'(i_ack), 32'd0);

    // ---- fetch + load together: data first, then fetch ----
    step();
    wait_n = 0;
    sb.push_back('{is_data: 1'b1, rdata: 32'h1234_5678});
    sb.push_back('{is_data: 1'b0, rdata: 32'h0000_0013});
    i_req = 1'b1; i_addr = 32'h20; d_read = 1'b1; d_addr = 32'h200;
    wait_ack(20, lat, nrd, nwr, fa, fw, fb, st0);
    chk("both_d_lat", lat, 32'd3);
    chk("both_d_mread", nrd, 32'd2);
    chk("both_d_maddr", fa, 32'h200);
    step(); d_read = 1'b0;
    wait_ack(20, lat, nrd, nwr, fa, fw, fb, st0);
    chk("both_f_lat", lat, 32'd3);
    chk("both_f_maddr", fa, 32'h20);
    step();                 // fetch port still holding i_req after its ack
    step(); i_req = 1'b0;
    watch_idle("both_no_reissue", 4);

    // ---- store byte, no wait ----
    step();
    sb.push_back('{is_data: 1'b1, rdata: 32'h1234_5678});  // d_rdata untouched
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hAB; d_be = BE_B;
    wait_ack(20, lat, nrd, nwr, fa, fw, fb, st0);
    chk("st_lat", lat, 32'd3);
    chk("st_mwrite_cycles", nwr, 32'd2);
    chk("st_mread_cycles", nrd, 32'd0);
    chk("st_maddr", fa, 32'h100);
    chk("st_mwdata", fw, 32'hAB);
    chk("st_mbe", 32'(fb), 32'h1);
    step();                 // store port still holding d_write after its ack
    step(); d_write = 1'b0;
    watch_idle("st_no_reissue", 4);
    chk("err_clean", 32'(err), 32'd0);

    // ---- load with memory stuck busy: timeout abort ----
    step();
    stuck = 1'b1;
    sb.push_back('{is_data: 1'b1, rdata: BUS_ABORT_DATA});
    d_read = 1'b1; d_addr = 32'h300;
    wait_ack(40, lat, nrd, nwr, fa, fw, fb, st0);
    chk("to_lat", lat, 32'(TO + 2));
    chk("to_mread_cycles", nrd, 32'(TO + 1));
    chk("to_err", 32'(err), 32'd1);
    step(); d_read = 1'b0; stuck = 1'b0;
    watch_idle("to_idle", 3);
    chk("to_err_sticky", 32'(err), 32'd1);

    // ---- reset in second DREAD cycle ----
    step();
    wait_n = 5;
    d_read = 1'b1; d_addr = 32'h200;
    step();
    @(negedge clk);
    chk("rst_mid_mread_c1", 32'(m_read), 32'd1);
    step(); rst = 1'b1; d_read = 1'b0;
    step();
    @(negedge clk);
    chk("rst_mid_mread", 32'(m_read), 32'd0);
    chk("rst_mid_dack", 32'(d_ack), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    step(); rst = 1'b0;
    watch_idle("rst_mid_idle", 3);

    // ---- read and write together: store wins, err set ----
    step();
    wait_n = 0;
    sb.push_back('{is_data: 1'b1, rdata: 32'h0});
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'h55; d_be = BE_W;
    wait_ack(20, lat, nrd, nwr, fa, fw, fb, st0);
    chk("ill_lat", lat, 32'd3);
    chk("ill_mread_cycles", nrd, 32'd0);
    chk("ill_mwrite_cycles", nwr, 32'd2);
    chk("ill_mwdata", fw, 32'h55);
    chk("ill_err", 32'(err), 32'd1);
    step(); d_read = 1'b0; d_write = 1'b0;
    watch_idle("ill_idle", 3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    step(); rst = 1'b1;
    step();
    @(negedge clk);
    chk("err_cleared_by_rst", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the core's instruction-fetch port and its load/store data port.
- Sits between the single-cycle core (fetch address / memRead / memWrite / memload paths) and the memory model.
- Runs a registered access FSM with a busy/ack handshake, fetch/data arbitration, and a per-access timeout watchdog.
- Drives a stall signal that freezes the core's PC and register write-back while an access is outstanding.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 255, max cycles an access may wait on m_busy before abort (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address, word aligned
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  DATA_W  fetched instruction, valid while i_ack=1
d_read  in  1  load request, held until d_ack
d_write  in  1  store request, held until d_ack
d_addr  in  ADDR_W  load/store address
d_wdata  in  DATA_W  store data
d_be  in  4  byte enables (SB=0001<<off, SH=0011<<off, SW=1111)
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid while d_ack=1
m_read  out  1  memory read strobe
m_write  out  1  memory write strobe
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  4  memory byte enables (1111 on reads)
m_busy  in  1  memory busy; low = current access complete
m_rdata  in  DATA_W  memory read data, sampled at completion
stall  out  1  (i_req & ~i_ack) | ((d_read|d_write) & ~d_ack), combinational
err  out  1  sticky protocol/timeout error flag

Behaviour:
- Reset: FSM=IDLE; all registered outputs 0 (acks, rdata, strobes, m_addr, m_wdata, m_be, err); last_grant=FETCH; timeout count 0. A reset during an access drops strobes at the next edge; no ack is issued.
- States: IDLE, FETCH, DREAD, DWRITE, RESP.
- IDLE arbitration, evaluated each cycle:
  - data wins over fetch;
  - exception: if last_grant=DATA and i_req=1, fetch wins;
  - d_write=1 selects DWRITE, else d_read=1 selects DREAD;
  - on grant, register m_addr/m_wdata/m_be and assert the strobe from the next cycle; update last_grant.
- Access state, first cycle: m_busy is ignored (memory has one cycle to raise it).
- Access state, later cycles: m_busy=0 marks the completion cycle C. At C: capture m_rdata into i_rdata or d_rdata (DWRITE leaves d_rdata unchanged) and go to RESP.
- RESP (cycle C+1): strobes 0; the granted requester's ack=1 for exactly this cycle; next state IDLE. Minimum latency from request seen in IDLE to ack is 3 cycles.
- Re-issue guard: in the IDLE cycle after RESP (C+2), the just-acked requester is ineligible, because it is still holding its request while it reacts to the ack.
- Timeout:
  - an 8-bit counter clears on entering an access state and increments each access cycle with m_busy=1;
  - at count==TIMEOUT, abort: the rdata register loads 32'hDEADBEEF (reads), err<=1, go to RESP and ack normally.
- Illegal request: d_read & d_write both high in IDLE sets err<=1; the store is performed.
- err clears only on rst.
- Strobes, m_addr, m_wdata and m_be stay stable for the entire access; m_read and m_write are never both high.
- Request inputs are sampled only in IDLE; changes mid-access are ignored.

Decomposition:
- Shared package mem_bus_pkg:
  - arb_state_t enum (IDLE, FETCH, DREAD, DWRITE, RESP);
  - grant_t enum (FETCH, DATA);
  - constant BUS_ABORT_DATA = 32'hDEADBEEF;
  - byte-enable constants BE_B/BE_H/BE_W.
- One sub-module, bus_timeout_ctr: clear/enable/limit inputs, expired output.

Test Plan:
- Fetch only, i_addr=32'h0000_0010, m_busy high 2 cycles then low, m_rdata=32'h3e800093 -> m_read high for 3 cycles, i_ack pulses 1 cycle, i_rdata=32'h3e800093, stall low the cycle after the ack.
- Store, d_addr=32'h100, d_wdata=32'h0000_00AB, d_be=4'b0001, no wait -> m_write high with m_be=0001 for 2 cycles, d_ack at cycle 3, i_ack stays 0.
- i_req and d_read asserted together and held across two transactions -> data served first, then fetch; no double ack, and neither requester is re-issued in its own post-ack cycle.
- Load with m_busy stuck high, TIMEOUT=4 -> abort after 4 busy cycles, d_rdata=32'hDEADBEEF, d_ack pulses, err=1 and stays 1 until rst.
- rst asserted in the second cycle of DREAD -> next edge gives m_read=0, no d_ack, FSM in IDLE, err=0.
- d_read=d_write=1 in IDLE, d_wdata=32'h55 -> write performed, err=1, m_read never asserted.
